stopwatch_lap: RTL
==================

// Module: stopwatch_lap
// PURPOSE
//  Parametrised stopwatch with hours field, clear, and lap capture into a small FWFT FIFO.
//  Divides clk to a centisecond tick and counts hour:min:sec:csec while run is high.
//  Feeds the digital-clock display/mux and a bus reader that drains lap times.
// PARAMETERS
//  CLK_HZ     25_000_000  input clock frequency, Hz
//  TICK_HZ    100         count resolution, Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2, exact division required
//  HOUR_MAX   99          last hour value before full wrap to 00:00:00.00 (<= 255)
//  LAP_DEPTH  4           lap FIFO entries, power of two, >= 2
// PORTS
//  clk           in   1    system clock
//  reset         in   1    synchronous, active-high reset
//  run           in   1    level: 1 = counting, 0 = frozen
//  clear         in   1    pulse: zero time and divider, clear lap_overflow
//  lap           in   1    pulse: push current timer into lap FIFO
//  lap_rd        in   1    pulse: pop FIFO head (ignored when lap_valid=0)
//  timer         out  32   {hour[7:0], min[7:0], sec[7:0], csec[7:0]}, binary
//  running       out  1    registered copy of run
//  lap_data      out  32   FIFO head, same packing as timer; 0 when empty
//  lap_valid     out  1    FIFO non-empty
//  lap_count     out  $clog2(LAP_DEPTH+1)  entries held
//  lap_overflow  out  1    sticky: a lap was dropped on full FIFO
// BEHAVIOUR
//  - Reset: timer=0, divider=0, running=0, FIFO empty, lap_data=0, lap_valid=0, lap_count=0, lap_overflow=0.
//  - Divider counts 0..DIV-1 only while run=1; run=0 holds divider and fields (no re-zero on restart).
//  - Tick = run && divider==DIV-1; divider wraps to 0; fields update on the same clock edge.
//  - Carry chain on tick: csec 0..99 -> sec 0..59 -> min 0..59 -> hour 0..HOUR_MAX;
//    at HOUR_MAX:59:59.99 all fields wrap to 0; no overflow flag for time.
//  - Fields never take illegal values; no 8-bit arithmetic wrap used.
//  - clear: divider and all fields = 0 next edge, overrides tick; lap_overflow=0; FIFO contents kept.
//  - lap: captures timer as registered in that cycle (pre-tick, pre-clear value); visible in FIFO next edge.
//  - FWFT: lap_data/lap_valid reflect head combinationally from registered FIFO state.
//  - Push on empty: lap_valid=1 the following cycle with lap_data = captured value.
//  - lap_rd && lap_valid: pop; lap_rd on empty ignored, no state change.
//  - Full, lap without lap_rd: entry dropped, contents unchanged, lap_overflow=1 next edge.
//  - Full, lap && lap_rd same cycle: pop and push both occur, lap_count stays LAP_DEPTH, no overflow.
//  - Empty, lap && lap_rd same cycle: push only (rd ignored).
//  - Priority: reset > clear > tick for time; reset > push/pop for FIFO; clear and lap same cycle: both act.
//  - reset mid-count or mid-drain: everything returns to reset values next edge, no partial state.
//  - All outputs registered except lap_data/lap_valid (mux from FIFO registers, no input-to-output path).
// STRUCTURE
//  - Package stopwatch_pkg: CSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, FIELD_W=8, TIME_W=32,
//    typedef packed struct time_t {hour, min, sec, csec}; pack/unpack helpers.
//  - Sub-module lap_fifo (DEPTH, WIDTH=32): FWFT, push/pop/count/full/empty; overflow detection stays in top.
//  - Top holds divider, carry chain, run register, overflow flag.
// TESTING  (sim params CLK_HZ=400, TICK_HZ=100 -> DIV=4, HOUR_MAX=1, LAP_DEPTH=4)
//  - reset, run=1 for 400 clks -> timer = 00:00:01.00 (0x00000100), running=1.
//  - run=1 to 00:00:00.05, run=0 for 50 clks, run=1 4 clks -> timer holds 0x05 while paused, then 0x06.
//  - preload path: run through 01:59:59.99 -> next tick timer=0x00000000; 00:59:59.99 -> 0x01000000.
//  - lap at 0x00000003, 0x00000107 -> lap_count=2, lap_data=0x03; lap_rd -> lap_data=0x0107; lap_rd -> lap_valid=0, lap_data=0.
//  - 5 laps with no reads -> lap_count=4, lap_overflow=1, head = first lap; clear -> overflow=0, timer=0, count=4.
//  - full FIFO, lap&&lap_rd same cycle -> count=4, overflow=0, new tail = timer; clear&&lap same cycle -> pushed value = pre-clear timer.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: field limits, packed time type and pack/unpack helpers
package stopwatch_pkg;
    localparam int CSEC_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int FIELD_W  = 8;
    localparam int TIME_W   = 32;

    typedef struct packed {
        logic [FIELD_W-1:0] hour;
        logic [FIELD_W-1:0] min;
        logic [FIELD_W-1:0] sec;
        logic [FIELD_W-1:0] csec;
    } time_t;

    function automatic logic [TIME_W-1:0] pack_time(time_t t);
        return {t.hour, t.min, t.sec, t.csec};
    endfunction

    function automatic time_t unpack_time(logic [TIME_W-1:0] v);
        time_t t;
        {t.hour, t.min, t.sec, t.csec} = v;
        return t;
    endfunction
endpackage

// File: rtl/lap_fifo.sv
// lap_fifo: first-word-fall-through FIFO, head is zero when empty
module lap_fifo
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = TIME_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           valid,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_pop, do_push;
    assign valid   = count != '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && valid;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: centisecond stopwatch with hours and lap capture FIFO
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 25_000_000,
    parameter int TICK_HZ   = 100,
    parameter int HOUR_MAX  = 99,
    parameter int LAP_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              run,
    input  logic                              clear,
    input  logic                              lap,
    input  logic                              lap_rd,
    output logic [TIME_W-1:0]                 timer,
    output logic                              running,
    output logic [TIME_W-1:0]                 lap_data,
    output logic                              lap_valid,
    output logic [$clog2(LAP_DEPTH+1)-1:0]    lap_count,
    output logic                              lap_overflow
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = $clog2(DIV);
    logic [DW-1:0] div_cnt;
    time_t         t, nt;
    logic          tick, c_w, s_w, m_w, h_w, full, drop;
    assign tick = run && div_cnt == DW'(DIV-1);
    // each wrap flag means this field and every lower one roll over on the tick
    assign c_w = t.csec == FIELD_W'(CSEC_MAX);
    assign s_w = c_w && t.sec == FIELD_W'(SEC_MAX);
    assign m_w = s_w && t.min == FIELD_W'(MIN_MAX);
    assign h_w = m_w && t.hour == FIELD_W'(HOUR_MAX);
    assign nt.csec = c_w ? '0 : t.csec + 8'd1;
    assign nt.sec  = s_w ? '0 : c_w ? t.sec + 8'd1 : t.sec;
    assign nt.min  = m_w ? '0 : s_w ? t.min + 8'd1 : t.min;
    assign nt.hour = h_w ? '0 : m_w ? t.hour + 8'd1 : t.hour;
    assign drop  = lap && full && !lap_rd;
    assign timer = pack_time(t);
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= '0;
            t            <= '0;
            running      <= 1'b0;
            lap_overflow <= 1'b0;
        end else begin
            running      <= run;
            lap_overflow <= drop || (lap_overflow && !clear);
            if (clear) begin
                div_cnt <= '0;
                t       <= '0;
            end else if (run) begin
                div_cnt <= tick ? '0 : div_cnt + DW'(1);
                t       <= tick ? nt : t;
            end
        end
    end
    lap_fifo #(.DEPTH(LAP_DEPTH), .WIDTH(TIME_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (lap),
        .pop   (lap_rd),
        .din   (pack_time(t)),
        .dout  (lap_data),
        .valid (lap_valid),
        .full  (full),
        .count (lap_count)
    );
endmodule
